// File: rtl/axi4l_decouple_ctrl.sv
// Purpose: drains AXI4-Lite control traffic, then enables the decoupler (forced after a timeout).
// Latency: decouple_enable rises 1 cycle after the drain completes; gating of AW/AR is combinational.
// Backpressure: new AW/AR are stalled (ready=0) outside COUPLED; a valid already shown downstream is held until accepted.
module axi4l_decouple_ctrl #(
  parameter int CNT_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 user_clk,
  input  logic                 reset_n,
  input  logic                 decouple_req,
  output logic                 decouple_enable,
  input  logic                 decouple_status,
  output logic                 decouple_done,
  output logic                 drain_timeout,
  input  logic                 s_axi_awvalid,
  output logic                 s_axi_awready,
  output logic                 m_axi_awvalid,
  input  logic                 m_axi_awready,
  input  logic                 s_axi_arvalid,
  output logic                 s_axi_arready,
  output logic                 m_axi_arvalid,
  input  logic                 m_axi_arready,
  input  logic                 s_axi_wvalid,
  input  logic                 s_axi_wready,
  input  logic                 s_axi_bvalid,
  input  logic                 s_axi_bready,
  input  logic                 s_axi_rvalid,
  input  logic                 s_axi_rready,
  output logic [CNT_WIDTH-1:0] wr_outstanding,
  output logic [CNT_WIDTH-1:0] rd_outstanding
);

  typedef enum logic [1:0] {
    ST_COUPLED   = 2'd0,
    ST_DRAIN     = 2'd1,
    ST_DECOUPLED = 2'd2
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [15:0]          TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   aw_cnt_q, aw_cnt_d;
  logic [CNT_WIDTH-1:0]   w_cnt_q, w_cnt_d;
  logic [CNT_WIDTH-1:0]   rd_cnt_q, rd_cnt_d;
  logic                   aw_hold_q, aw_hold_d;
  logic                   ar_hold_q, ar_hold_d;
  logic [15:0]            to_cnt_q, to_cnt_d;
  logic                   drain_to_q, drain_to_d;
  logic                   dec_en_q;
  logic                   force_clr;

  logic awhs, whs, bhs, arhs, rhs;
  logic aw_allow, ar_allow;
  logic quiescent;

  // Saturating up/down counter step: simultaneous inc and dec cancel out.
  function automatic logic [CNT_WIDTH-1:0] cnt_step(
    input logic [CNT_WIDTH-1:0] cnt,
    input logic                 inc,
    input logic                 dec
  );
    logic [CNT_WIDTH-1:0] r;
    r = cnt;
    if (inc && !dec && (cnt != CNT_MAX)) begin
      r = cnt + 1'b1;
    end else if (dec && !inc && (cnt != '0)) begin
      r = cnt - 1'b1;
    end
    return r;
  endfunction

  // Address gating: allow never looks at valid, so ready/valid stay AXI-legal.
  always_comb begin
    aw_allow = aw_hold_q
             | ((state_q == ST_COUPLED) & (aw_cnt_q != CNT_MAX))
             | ((state_q == ST_DRAIN) & (w_cnt_q > aw_cnt_q));
    ar_allow = ar_hold_q
             | ((state_q == ST_COUPLED) & (rd_cnt_q != CNT_MAX));

    m_axi_awvalid = s_axi_awvalid & aw_allow;
    s_axi_awready = m_axi_awready & aw_allow;
    m_axi_arvalid = s_axi_arvalid & ar_allow;
    s_axi_arready = m_axi_arready & ar_allow;

    awhs = s_axi_awvalid & s_axi_awready;
    arhs = s_axi_arvalid & s_axi_arready;
    whs  = s_axi_wvalid  & s_axi_wready;
    bhs  = s_axi_bvalid  & s_axi_bready;
    rhs  = s_axi_rvalid  & s_axi_rready;

    quiescent = (aw_cnt_q == '0) & (w_cnt_q == '0) & (rd_cnt_q == '0)
              & ~aw_hold_q & ~ar_hold_q;
  end

  // FSM next state, drain timer and sticky timeout flag.
  always_comb begin
    state_d    = state_q;
    to_cnt_d   = to_cnt_q;
    drain_to_d = drain_to_q;
    force_clr  = 1'b0;
    case (state_q)
      ST_COUPLED: begin
        if (decouple_req) begin
          state_d    = ST_DRAIN;
          to_cnt_d   = '0;
          drain_to_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (!decouple_req) begin
          state_d = ST_COUPLED;
        end else if (quiescent) begin
          state_d = ST_DECOUPLED;
        end else if (to_cnt_q == TO_LAST) begin
          // Forced decouple: whatever is still in flight is abandoned.
          state_d    = ST_DECOUPLED;
          drain_to_d = 1'b1;
          force_clr  = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
      end
      ST_DECOUPLED: begin
        if (!decouple_req) begin
          state_d = ST_COUPLED;
        end
      end
      default: begin
        state_d = ST_COUPLED;
      end
    endcase
  end

  // Outstanding counters and hold flags; a forced decouple wipes them.
  always_comb begin
    aw_cnt_d  = cnt_step(aw_cnt_q, awhs, bhs);
    w_cnt_d   = cnt_step(w_cnt_q, whs, bhs);
    rd_cnt_d  = cnt_step(rd_cnt_q, arhs, rhs);
    aw_hold_d = aw_hold_q;
    ar_hold_d = ar_hold_q;
    if (awhs) begin
      aw_hold_d = 1'b0;
    end else if (m_axi_awvalid && !m_axi_awready) begin
      aw_hold_d = 1'b1;
    end
    if (arhs) begin
      ar_hold_d = 1'b0;
    end else if (m_axi_arvalid && !m_axi_arready) begin
      ar_hold_d = 1'b1;
    end
    if (force_clr) begin
      aw_cnt_d  = '0;
      w_cnt_d   = '0;
      rd_cnt_d  = '0;
      aw_hold_d = 1'b0;
      ar_hold_d = 1'b0;
    end
  end

  // State, counter and flag registers.
  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_COUPLED;
      aw_cnt_q   <= '0;
      w_cnt_q    <= '0;
      rd_cnt_q   <= '0;
      aw_hold_q  <= 1'b0;
      ar_hold_q  <= 1'b0;
      to_cnt_q   <= '0;
      drain_to_q <= 1'b0;
      dec_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      aw_cnt_q   <= aw_cnt_d;
      w_cnt_q    <= w_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      aw_hold_q  <= aw_hold_d;
      ar_hold_q  <= ar_hold_d;
      to_cnt_q   <= to_cnt_d;
      drain_to_q <= drain_to_d;
      dec_en_q   <= (state_d == ST_DECOUPLED);
    end
  end

  assign decouple_enable = dec_en_q;
  assign decouple_done   = (state_q == ST_DECOUPLED) & decouple_status;
  assign drain_timeout   = drain_to_q;
  assign wr_outstanding  = aw_cnt_q;
  assign rd_outstanding  = rd_cnt_q;

endmodule

// File: tb/tb_axi4l_decouple_ctrl.sv
// Purpose: directed bench for axi4l_decouple_ctrl (CNT_WIDTH=2, TIMEOUT_CYCLES=16).
// Latency: inputs change 1ns after a rising edge; outputs are checked before the next edge.
// Backpressure: downstream ready is driven directly to exercise stall and hold behaviour.
module tb_axi4l_decouple_ctrl;

  localparam int CW = 2;
  localparam int TO = 16;

  logic          user_clk = 1'b0;
  logic          reset_n;
  logic          decouple_req, decouple_status;
  logic          decouple_enable, decouple_done, drain_timeout;
  logic          s_axi_awvalid, s_axi_awready, m_axi_awvalid, m_axi_awready;
  logic          s_axi_arvalid, s_axi_arready, m_axi_arvalid, m_axi_arready;
  logic          s_axi_wvalid, s_axi_wready, s_axi_bvalid, s_axi_bready;
  logic          s_axi_rvalid, s_axi_rready;
  logic [CW-1:0] wr_outstanding, rd_outstanding;

  int n_chk  = 0;
  int n_pass = 0;

  axi4l_decouple_ctrl #(.CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)) dut (
    .user_clk        (user_clk),
    .reset_n         (reset_n),
    .decouple_req    (decouple_req),
    .decouple_enable (decouple_enable),
    .decouple_status (decouple_status),
    .decouple_done   (decouple_done),
    .drain_timeout   (drain_timeout),
    .s_axi_awvalid   (s_axi_awvalid),
    .s_axi_awready   (s_axi_awready),
    .m_axi_awvalid   (m_axi_awvalid),
    .m_axi_awready   (m_axi_awready),
    .s_axi_arvalid   (s_axi_arvalid),
    .s_axi_arready   (s_axi_arready),
    .m_axi_arvalid   (m_axi_arvalid),
    .m_axi_arready   (m_axi_arready),
    .s_axi_wvalid    (s_axi_wvalid),
    .s_axi_wready    (s_axi_wready),
    .s_axi_bvalid    (s_axi_bvalid),
    .s_axi_bready    (s_axi_bready),
    .s_axi_rvalid    (s_axi_rvalid),
    .s_axi_rready    (s_axi_rready),
    .wr_outstanding  (wr_outstanding),
    .rd_outstanding  (rd_outstanding)
  );

  always #5 user_clk = ~user_clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  // Advance to just after the next rising edge.
  task automatic nxt();
    @(posedge user_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    decouple_req = 0; decouple_status = 0;
    s_axi_awvalid = 0; m_axi_awready = 1;
    s_axi_arvalid = 0; m_axi_arready = 1;
    s_axi_wvalid = 0; s_axi_wready = 0;
    s_axi_bvalid = 0; s_axi_bready = 0;
    s_axi_rvalid = 0; s_axi_rready = 0;
    repeat (3) nxt();

    // Reset state: nothing outstanding, AW passes straight through.
    chk("rst_en", decouple_enable, 0);
    chk("rst_to", drain_timeout, 0);
    chk("rst_wr", wr_outstanding, 0);
    chk("rst_rd", rd_outstanding, 0);
    s_axi_awvalid = 1; settle();
    chk("rst_awrdy", s_axi_awready, 1);
    chk("rst_mawv", m_axi_awvalid, 1);
    s_axi_awvalid = 0;
    reset_n = 1'b1;
    repeat (2) nxt();

    // Idle bus decouple: req at N, DRAIN at N+1 (AR blocked), enable at N+2.
    decouple_req = 1;
    nxt();
    s_axi_arvalid = 1; settle();
    chk("t1_drain_arrdy", s_axi_arready, 0);
    chk("t1_drain_marv", m_axi_arvalid, 0);
    chk("t1_drain_en", decouple_enable, 0);
    s_axi_arvalid = 0;
    nxt();
    chk("t1_en", decouple_enable, 1);
    chk("t1_done0", decouple_done, 0);
    decouple_status = 1; settle();
    chk("t1_done1", decouple_done, 1);
    decouple_req = 0; decouple_status = 0;
    nxt();
    chk("t1_recouple_en", decouple_enable, 0);
    s_axi_arvalid = 1; settle();
    chk("t1_recouple_arrdy", s_axi_arready, 1);
    s_axi_arvalid = 0;
    nxt();

    // Write in flight with B held off: new AW blocked, enable 2 cycles after bhs.
    s_axi_awvalid = 1; s_axi_wvalid = 1; s_axi_wready = 1; settle();
    chk("t2_aw_acc", s_axi_awready, 1);
    nxt();
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    chk("t2_wr1", wr_outstanding, 1);
    decouple_req = 1;
    nxt();
    s_axi_awvalid = 1; settle();
    chk("t2_aw_blk", s_axi_awready, 0);
    chk("t2_maw_blk", m_axi_awvalid, 0);
    repeat (8) nxt();
    chk("t2_en_wait", decouple_enable, 0);
    chk("t2_aw_blk2", s_axi_awready, 0);
    s_axi_bvalid = 1; s_axi_bready = 1;
    nxt();
    s_axi_bvalid = 0; s_axi_bready = 0;
    chk("t2_wr0", wr_outstanding, 0);
    chk("t2_en_k1", decouple_enable, 0);
    nxt();
    chk("t2_en_k2", decouple_enable, 1);
    chk("t2_to", drain_timeout, 0);
    chk("t2_aw_blk_dec", s_axi_awready, 0);
    s_axi_awvalid = 0; decouple_req = 0;
    repeat (2) nxt();

    // W ahead of AW: the AW is still let through in DRAIN.
    s_axi_wvalid = 1;
    nxt();
    s_axi_wvalid = 0;
    decouple_req = 1;
    nxt();
    s_axi_awvalid = 1; settle();
    chk("t3_aw_drain", s_axi_awready, 1);
    chk("t3_maw_drain", m_axi_awvalid, 1);
    nxt();
    s_axi_awvalid = 0;
    chk("t3_wr1", wr_outstanding, 1);
    chk("t3_en0", decouple_enable, 0);
    s_axi_bvalid = 1; s_axi_bready = 1;
    nxt();
    s_axi_bvalid = 0; s_axi_bready = 0; s_axi_wready = 0;
    chk("t3_wr0", wr_outstanding, 0);
    nxt();
    chk("t3_en", decouple_enable, 1);
    decouple_req = 0;
    repeat (2) nxt();

    // Timeout: AR never answered; enable at N+17 for req raised at N.
    s_axi_arvalid = 1; settle();
    chk("t4_ar_acc", s_axi_arready, 1);
    nxt();
    s_axi_arvalid = 0;
    chk("t4_rd1", rd_outstanding, 1);
    decouple_req = 1;
    repeat (16) nxt();
    chk("t4_en_n16", decouple_enable, 0);
    chk("t4_to_n16", drain_timeout, 0);
    nxt();
    chk("t4_en_n17", decouple_enable, 1);
    chk("t4_to", drain_timeout, 1);
    chk("t4_rd0", rd_outstanding, 0);
    decouple_req = 0;
    nxt();
    chk("t4_to_sticky", drain_timeout, 1);
    decouple_req = 1;
    nxt();
    chk("t4_to_clr", drain_timeout, 0);
    decouple_req = 0;
    repeat (2) nxt();

    // Valid already presented downstream is held through DRAIN until accepted.
    m_axi_awready = 0; s_axi_awvalid = 1; decouple_req = 1; settle();
    chk("t5_mawv0", m_axi_awvalid, 1);
    nxt();
    chk("t5_mawv_drain", m_axi_awvalid, 1);
    nxt();
    chk("t5_mawv_drain2", m_axi_awvalid, 1);
    chk("t5_en_hold", decouple_enable, 0);
    m_axi_awready = 1; settle();
    chk("t5_awrdy", s_axi_awready, 1);
    nxt();
    s_axi_awvalid = 0;
    chk("t5_wr1", wr_outstanding, 1);
    chk("t5_en0", decouple_enable, 0);
    s_axi_bvalid = 1; s_axi_bready = 1;
    nxt();
    s_axi_bvalid = 0; s_axi_bready = 0;
    chk("t5_wr0", wr_outstanding, 0);
    nxt();
    chk("t5_en", decouple_enable, 1);
    decouple_req = 0;
    repeat (2) nxt();

    // Saturation at CNT_MAX=3: the 4th AR waits for an R.
    s_axi_arvalid = 1; settle();
    chk("t6_ar1", s_axi_arready, 1);
    nxt();
    chk("t6_ar2", s_axi_arready, 1);
    nxt();
    chk("t6_ar3", s_axi_arready, 1);
    nxt();
    chk("t6_ar4_blk", s_axi_arready, 0);
    chk("t6_rd3", rd_outstanding, 3);
    s_axi_rvalid = 1; s_axi_rready = 1; settle();
    chk("t6_ar4_blk_r", s_axi_arready, 0);
    nxt();
    s_axi_rvalid = 0; s_axi_rready = 0; settle();
    chk("t6_rd2", rd_outstanding, 2);
    chk("t6_ar4_ok", s_axi_arready, 1);
    nxt();
    s_axi_arvalid = 0;
    chk("t6_rd3b", rd_outstanding, 3);
    s_axi_rvalid = 1; s_axi_rready = 1;
    repeat (2) nxt();
    s_axi_rvalid = 0; s_axi_rready = 0;
    chk("t6_rd1", rd_outstanding, 1);

    // Abort in DRAIN: back to COUPLED, enable never rises.
    decouple_req = 1;
    nxt();
    chk("t7_en_drain", decouple_enable, 0);
    s_axi_arvalid = 1; settle();
    chk("t7_ar_blk", s_axi_arready, 0);
    s_axi_arvalid = 0; decouple_req = 0;
    nxt();
    chk("t7_en_abort", decouple_enable, 0);
    s_axi_arvalid = 1; settle();
    chk("t7_ar_ok", s_axi_arready, 1);
    s_axi_arvalid = 0;
    nxt();
    chk("t7_en_abort2", decouple_enable, 0);
    s_axi_rvalid = 1; s_axi_rready = 1;
    nxt();
    s_axi_rvalid = 0; s_axi_rready = 0;
    chk("t7_rd0", rd_outstanding, 0);

    // Reset mid-DRAIN discards counts; reset in DECOUPLED drops enable at once.
    s_axi_arvalid = 1;
    nxt();
    s_axi_arvalid = 0;
    decouple_req = 1;
    repeat (2) nxt();
    reset_n = 0; settle();
    chk("t8_rst_rd", rd_outstanding, 0);
    chk("t8_rst_en", decouple_enable, 0);
    nxt();
    reset_n = 1;
    repeat (3) nxt();
    chk("t8_en_again", decouple_enable, 1);
    #2 reset_n = 0; settle();
    chk("t8_async_en", decouple_enable, 0);
    decouple_req = 0;
    nxt();
    reset_n = 1;
    nxt();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
